// File: rtl/uart_alu_host_pkg.sv
// Shared types, header constants and length-field helper for the UART ALU host engine.
package uart_alu_host_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSendHdr,
    StSendOps,
    StWaitRsp,
    StDone
  } state_e;

  localparam logic [7:0]  HdrReserved = 8'h00;
  localparam int unsigned HdrLen      = 4;

  // Packet length field: header plus n operands of b bytes each.
  function automatic logic [15:0] calc_len(input int unsigned n, input int unsigned b);
    calc_len = 16'(HdrLen + n * b);
  endfunction

endpackage

// File: rtl/uart_alu_host_timer.sv
// Idle-cycle counter for the response timeout; only built with UART_ALU_HOST_TIMEOUT_EN.
module uart_alu_host_timer #(
  parameter int unsigned LIMIT_P = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(LIMIT_P + 1);

  logic [CntW-1:0] r_cnt;

  assign expired_o = (r_cnt == CntW'(LIMIT_P));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && !expired_o) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_alu_host.sv
// Host command engine: frames one command onto the UART tx stream and assembles the response.
// Optional response timeout is enabled by defining UART_ALU_HOST_TIMEOUT_EN.
module uart_alu_host
  import uart_alu_host_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH_P  = 32,
  parameter int unsigned MAX_OPERANDS_P   = 4,
  parameter int unsigned TIMEOUT_CYCLES_P = 1000000
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cmd_valid_i,
  output logic                                      cmd_ready_o,
  input  logic [7:0]                                cmd_opcode_i,
  input  logic [$clog2(MAX_OPERANDS_P+1)-1:0]       cmd_count_i,
  input  logic [MAX_OPERANDS_P*OPERAND_WIDTH_P-1:0] cmd_operands_i,
  output logic [7:0]                                tx_data_o,
  output logic                                      tx_valid_o,
  input  logic                                      tx_ready_i,
  input  logic [7:0]                                rx_data_i,
  input  logic                                      rx_valid_i,
  output logic                                      rx_ready_o,
  output logic [OPERAND_WIDTH_P-1:0]                rsp_data_o,
  output logic                                      rsp_valid_o,
  input  logic                                      rsp_ready_i,
  output logic                                      rsp_timeout_o,
  output logic                                      busy_o
);

  localparam int unsigned W       = OPERAND_WIDTH_P;
  localparam int unsigned B       = W / 8;
  localparam int unsigned CntW    = $clog2(MAX_OPERANDS_P + 1);
  localparam int unsigned OpsW    = MAX_OPERANDS_P * W;
  localparam int unsigned IdxW    = $clog2(HdrLen + MAX_OPERANDS_P * B + 1);
  localparam int unsigned OpsSelW = $clog2(OpsW);
  localparam int unsigned RspSelW = $clog2(W);

  if ((W % 8) != 0 || W < 8 || W > 64 || MAX_OPERANDS_P < 1 || TIMEOUT_CYCLES_P < 1)
  begin : g_bad_params
    $error("uart_alu_host: illegal parameter combination");
  end

  state_e            r_state, w_next;
  logic              r_armed;
  logic [7:0]        r_opcode;
  logic [CntW-1:0]   r_n;
  logic [OpsW-1:0]   r_ops;
  logic [IdxW-1:0]   r_idx;
  logic [W-1:0]      r_rsp;

  logic              w_accept, w_tx_hs, w_rx_hs, w_expired;
  logic              w_hdr_last, w_ops_last, w_rsp_last;
  logic [CntW-1:0]   w_n_sat;
  logic [15:0]       w_len;
  logic [OpsSelW-1:0] w_op_lsb;
  logic [RspSelW-1:0] w_rsp_lsb;
  logic [7:0]        w_tx_data;

  assign w_accept   = cmd_valid_i && cmd_ready_o;
  assign w_tx_hs    = tx_valid_o && tx_ready_i;
  assign w_rx_hs    = rx_valid_i && rx_ready_o;
  assign w_n_sat    = (cmd_count_i > CntW'(MAX_OPERANDS_P)) ? CntW'(MAX_OPERANDS_P) : cmd_count_i;
  assign w_len      = calc_len(32'(r_n), B);
  assign w_hdr_last = (r_idx == IdxW'(HdrLen - 1));
  assign w_ops_last = (16'(r_idx) == (w_len - 16'd1));
  assign w_rsp_last = (r_idx == IdxW'(B - 1));
  // Operand bytes are stored LSB-first, so the byte offset past the header addresses r_ops.
  assign w_op_lsb   = OpsSelW'({r_idx - IdxW'(HdrLen), 3'b000});
  assign w_rsp_lsb  = RspSelW'({r_idx, 3'b000});

  always_comb begin
    w_tx_data = 8'h00;
    if (r_state == StSendHdr) begin
      case (r_idx[1:0])
        2'd0:    w_tx_data = r_opcode;
        2'd1:    w_tx_data = HdrReserved;
        2'd2:    w_tx_data = w_len[7:0];
        default: w_tx_data = w_len[15:8];
      endcase
    end else if (r_state == StSendOps) begin
      w_tx_data = r_ops[w_op_lsb +: 8];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      StIdle:    if (w_accept) w_next = StSendHdr;
      StSendHdr: if (w_tx_hs && w_hdr_last) w_next = (r_n != '0) ? StSendOps : StWaitRsp;
      StSendOps: if (w_tx_hs && w_ops_last) w_next = StWaitRsp;
      StWaitRsp: begin
        if (w_rx_hs) begin
          if (w_rsp_last) w_next = StDone;
        end else if (w_expired) begin
          w_next = StDone;
        end
      end
      StDone:    if (rsp_ready_i) w_next = StIdle;
      default:   w_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed  <= 1'b0;
      r_opcode <= '0;
      r_n      <= '0;
      r_ops    <= '0;
      r_idx    <= '0;
      r_rsp    <= '0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_opcode <= cmd_opcode_i;
            r_n      <= w_n_sat;
            r_ops    <= cmd_operands_i;
            r_idx    <= '0;
            r_rsp    <= '0;
          end
        end
        StSendHdr, StSendOps: begin
          // The byte counter restarts at zero to count response bytes.
          if (w_tx_hs) r_idx <= (w_next == StWaitRsp) ? '0 : r_idx + 1'b1;
        end
        StWaitRsp: begin
          if (w_rx_hs) begin
            r_rsp[w_rsp_lsb +: 8] <= rx_data_i;
            r_idx                 <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UART_ALU_HOST_TIMEOUT_EN
  logic w_tmr_clr, w_tmr_en, r_tmo;

  // Held clear outside WAIT_RSP, so the count starts from zero on entry.
  assign w_tmr_clr = (r_state != StWaitRsp) || w_rx_hs;
  assign w_tmr_en  = (r_state == StWaitRsp);

  uart_alu_host_timer #(
    .LIMIT_P (TIMEOUT_CYCLES_P)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (w_tmr_clr),
    .en_i      (w_tmr_en),
    .expired_o (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo <= 1'b0;
    end else if (w_accept) begin
      r_tmo <= 1'b0;
    end else if (r_state == StWaitRsp && !w_rx_hs && w_expired) begin
      r_tmo <= 1'b1;
    end
  end

  assign rsp_timeout_o = r_tmo;
`else
  assign w_expired     = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  assign cmd_ready_o = r_armed && (r_state == StIdle);
  assign tx_valid_o  = (r_state == StSendHdr) || (r_state == StSendOps);
  assign tx_data_o   = w_tx_data;
  assign rx_ready_o  = r_armed && (r_state != StDone);
  assign rsp_valid_o = (r_state == StDone);
  assign rsp_data_o  = r_rsp;
  assign busy_o      = (r_state != StIdle);

endmodule

// File: tb/tb_uart_alu_host.sv
// Randomized self-checking bench for uart_alu_host against a queue-based packet/response model.
module tb_uart_alu_host;

  localparam int W    = 32;
  localparam int MAXN = 4;
  localparam int B    = W / 8;
  localparam int TMO  = 50;
  localparam int CW   = $clog2(MAXN + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cmd_valid_i = 1'b0;
  logic            cmd_ready_o;
  logic [7:0]      cmd_opcode_i = '0;
  logic [CW-1:0]   cmd_count_i = '0;
  logic [MAXN*W-1:0] cmd_operands_i = '0;
  logic [7:0]      tx_data_o;
  logic            tx_valid_o;
  logic            tx_ready_i = 1'b1;
  logic [7:0]      rx_data_i = '0;
  logic            rx_valid_i = 1'b0;
  logic            rx_ready_o;
  logic [W-1:0]    rsp_data_o;
  logic            rsp_valid_o;
  logic            rsp_ready_i = 1'b0;
  logic            rsp_timeout_o;
  logic            busy_o;

  uart_alu_host #(
    .OPERAND_WIDTH_P  (W),
    .MAX_OPERANDS_P   (MAXN),
    .TIMEOUT_CYCLES_P (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_opcode_i   (cmd_opcode_i),
    .cmd_count_i    (cmd_count_i),
    .cmd_operands_i (cmd_operands_i),
    .tx_data_o      (tx_data_o),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready_i),
    .rx_data_i      (rx_data_i),
    .rx_valid_i     (rx_valid_i),
    .rx_ready_o     (rx_ready_o),
    .rsp_data_o     (rsp_data_o),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_timeout_o  (rsp_timeout_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] tx_log[$];
  logic [7:0] rx_q[$];
  logic [W-1:0] c_ops[MAXN];
  logic [W-1:0] exp_rsp, got_rsp;
  logic       exp_tmo, got_tmo;
  bit         got_rsp_v, mon_en, in_cmd, in_done, tmo_phase, tx_rand;
  int         lat, lat_rsp;
  logic [7:0] basic_bytes[12] = '{8'h8A, 8'h00, 8'h0C, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                                  8'hDD, 8'hCC, 8'hBB, 8'hAA};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // tx_ready driver: either held high or toggled randomly
  initial forever begin
    @(posedge clk);
    #1;
    tx_ready_i = tx_rand ? 1'($urandom) : 1'b1;
  end

  // Compare process: runs every cycle against the model state
  always @(negedge clk) begin
    if (mon_en) begin
      lat++;
      chk("tx_valid", tx_valid_o, (in_cmd && (exp_tx.size() != 0)));
      if (tx_valid_o && exp_tx.size() != 0) begin
        chk("tx_data", tx_data_o, exp_tx[0]);
        if (tx_ready_i) begin
          tx_log.push_back(tx_data_o);
          void'(exp_tx.pop_front());
        end
      end
      chk("busy", busy_o, in_cmd);
      if (!tmo_phase) begin
        chk("rsp_valid", rsp_valid_o, in_done);
        chk("rx_ready", rx_ready_o, !in_done);
      end
      if (rsp_valid_o) begin
        chk("rsp_data", rsp_data_o, exp_rsp);
        chk("rsp_timeout", rsp_timeout_o, exp_tmo);
        if (!got_rsp_v) lat_rsp = lat;
        got_rsp   = rsp_data_o;
        got_tmo   = rsp_timeout_o;
        got_rsp_v = 1'b1;
      end
    end
  end

  // Build the expected tx byte stream and response from the command and rx_q
  task automatic prep(input logic [7:0] op, input int cnt, input int nrx);
    int n, len;
    n   = (cnt > MAXN) ? MAXN : cnt;
    len = 4 + n * B;
    exp_tx.delete();
    tx_log.delete();
    exp_tx.push_back(op);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'(len % 256));
    exp_tx.push_back(8'(len / 256));
    for (int k = 0; k < n; k++)
      for (int b = 0; b < B; b++) exp_tx.push_back(8'((c_ops[k] >> (8 * b)) & 'hFF));
    exp_rsp = '0;
    for (int j = 0; j < nrx && j < B; j++) exp_rsp = exp_rsp | (W'(rx_q[j]) << (8 * j));
    exp_tmo   = (nrx < B);
    got_rsp_v = 1'b0;
    got_rsp   = '0;
    got_tmo   = 1'b0;
  endtask

  task automatic accept(input logic [7:0] op, input int cnt);
    int k;
    k = 0;
    while (!cmd_ready_o && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("cmd_ready_wait", cmd_ready_o, 1);
    cmd_valid_i  = 1'b1;
    cmd_opcode_i = op;
    cmd_count_i  = CW'(cnt);
    for (int i = 0; i < MAXN; i++) cmd_operands_i[i*W +: W] = c_ops[i];
    @(posedge clk);
    #1;
    cmd_valid_i    = 1'b0;
    cmd_opcode_i   = 8'($urandom);
    cmd_count_i    = CW'($urandom);
    cmd_operands_i = {$urandom, $urandom, $urandom, $urandom};
    in_cmd = 1'b1;
    lat    = 0;
    chk("accept_tx_valid", tx_valid_o, 1);
    chk("accept_cmd_ready", cmd_ready_o, 0);
  endtask

  task automatic finish_cmd(input bit flush, input int nrx, input int delay);
    int k, gap;
    k = 0;
    while (exp_tx.size() != 0 && k < 2000) begin
      rx_valid_i = flush ? 1'($urandom) : 1'b0;
      rx_data_i  = 8'($urandom);
      @(posedge clk);
      #1;
      k++;
    end
    chk("tx_drained", 64'(exp_tx.size()), 0);
    for (int j = 0; j < nrx; j++) begin
      gap = flush ? $urandom_range(0, 2) : 0;
      repeat (gap) begin
        rx_valid_i = 1'b0;
        @(posedge clk);
        #1;
      end
      rx_valid_i = 1'b1;
      rx_data_i  = rx_q[j];
      @(posedge clk);
      #1;
    end
    rx_valid_i = 1'b0;
    if (nrx < B) begin
      tmo_phase = 1'b1;
      k = 0;
      while (!rsp_valid_o && k < 3 * TMO) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk("timeout_window", (k >= TMO - 1 && k <= TMO + 1), 1);
      tmo_phase = 1'b0;
    end
    in_done = 1'b1;
    repeat (delay) begin
      @(posedge clk);
      #1;
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
    in_cmd  = 1'b0;
    in_done = 1'b0;
    chk("cmd_ready_after_rsp", cmd_ready_o, 1);
  endtask

  task automatic run_cmd(input logic [7:0] op, input int cnt, input bit txr, input bit flush,
                         input int nrx, input int delay);
    tx_rand = txr;
    prep(op, cnt, nrx);
    accept(op, cnt);
    finish_cmd(flush, nrx, delay);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    logic [7:0] op;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_tx_valid", tx_valid_o, 0);
    chk("rst_tx_data", tx_data_o, 0);
    chk("rst_rx_ready", rx_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    chk("rst_rsp_timeout", rsp_timeout_o, 0);
    chk("rst_busy", busy_o, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("cmd_ready_after_rst", cmd_ready_o, 1);
    mon_en = 1'b1;

    // Basic command with ideal handshakes
    c_ops[0] = 32'h11223344; c_ops[1] = 32'hAABBCCDD; c_ops[2] = $urandom; c_ops[3] = $urandom;
    rx_q = '{8'h78, 8'h56, 8'h34, 8'h12};
    run_cmd(8'h8A, 2, 1'b0, 1'b0, B, 2);
    chk("basic_len", 64'(tx_log.size()), 12);
    for (int i = 0; i < 12 && i < tx_log.size(); i++) chk("basic_byte", tx_log[i], basic_bytes[i]);
    chk("basic_rsp", got_rsp, 32'h12345678);
    chk("basic_tmo", got_tmo, 0);
    chk("basic_latency", 64'(lat_rsp), 17);

    // Zero operands
    rx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_cmd(8'h8A, 0, 1'b0, 1'b0, B, 0);
    chk("zero_len", 64'(tx_log.size()), 4);
    if (tx_log.size() >= 4) chk("zero_lenfield", tx_log[2], 8'h04);
    chk("zero_rsp", got_rsp, 32'h04030201);

    // Saturated operand count
    for (int i = 0; i < MAXN; i++) c_ops[i] = $urandom;
    rx_q = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
    run_cmd(8'h21, 7, 1'b0, 1'b1, B, 1);
    chk("sat_len", 64'(tx_log.size()), 20);
    if (tx_log.size() >= 4) chk("sat_lenfield", {tx_log[3], tx_log[2]}, 16'h0014);

    // Tx backpressure: same stream as the basic case
    c_ops[0] = 32'h11223344; c_ops[1] = 32'hAABBCCDD;
    rx_q = '{8'h78, 8'h56, 8'h34, 8'h12};
    run_cmd(8'h8A, 2, 1'b1, 1'b0, B, 3);
    chk("bp_len", 64'(tx_log.size()), 12);
    for (int i = 0; i < 12 && i < tx_log.size(); i++) chk("bp_byte", tx_log[i], basic_bytes[i]);

`ifdef UART_ALU_HOST_TIMEOUT_EN
    rx_q = '{8'hEF, 8'hBE};
    run_cmd(8'h33, 1, 1'b0, 1'b0, 2, 2);
    chk("tmo_rsp", got_rsp, 32'h0000BEEF);
    chk("tmo_flag", got_tmo, 1);
`endif

    // Reset in the middle of a packet
    tx_rand = 1'b0;
    for (int i = 0; i < MAXN; i++) c_ops[i] = $urandom;
    rx_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    prep(8'h5C, 3, B);
    accept(8'h5C, 3);
    k = 0;
    while (tx_log.size() < 5 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("midrst_progress", 64'(tx_log.size()), 5);
    rst = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("midrst_tx_valid", tx_valid_o, 0);
    chk("midrst_cmd_ready", cmd_ready_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_rx_ready", rx_ready_o, 0);
    chk("midrst_rsp_valid", rsp_valid_o, 0);
    chk("midrst_rsp_data", rsp_data_o, 0);
    exp_tx.delete();
    in_cmd = 1'b0;
    in_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready_after", cmd_ready_o, 1);
    mon_en = 1'b1;
    c_ops[0] = 32'hDEADBEEF;
    rx_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    run_cmd(8'h77, 1, 1'b0, 1'b0, B, 0);
    if (tx_log.size() >= 5) begin
      chk("fresh_opcode", tx_log[0], 8'h77);
      chk("fresh_op0", tx_log[4], 8'hEF);
    end
    chk("fresh_len", 64'(tx_log.size()), 8);

    // Randomized commands
    for (int it = 0; it < 25; it++) begin
      op = 8'($urandom);
      for (int i = 0; i < MAXN; i++) c_ops[i] = $urandom;
      rx_q.delete();
      for (int j = 0; j < B; j++) rx_q.push_back(8'($urandom));
      run_cmd(op, $urandom_range(0, 7), 1'($urandom), 1'($urandom), B, $urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
